// File: rtl/alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_sequencer_if
// Instruction handshake between an instruction source and the ALU sequencer.
//   instr_valid  master -> slave  instr_data holds an instruction
//   instr_ready  slave  -> master sequencer accepts an instruction this cycle
//   instr_data   master -> slave  {opcode[9:6], rd[5:4], rs1[3:2], rs2[1:0]}
// ----------------------------------------------------------------------------
interface alu_sequencer_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] instr_data;

    modport master (output instr_valid, output instr_data, input instr_ready);
    modport slave  (input instr_valid, input instr_data, output instr_ready);
endinterface

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Issues one instruction at a time to an external ALU.  Operands are read from
// a four-entry 8-bit register file, the ALU opcode is held for WAIT_CYCLES
// EXEC cycles, and the ALU result is written back to rd together with a
// result/flags snapshot.  Sequence: IDLE -> SETUP -> EXEC (xWAIT_CYCLES) -> WB.
//
// Parameters
//   WAIT_CYCLES  EXEC cycles the opcode is held before sampling (1..15)
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   instr                 instruction handshake (alu_sequencer_if.slave)
//   wr_en/wr_addr/wr_data register preload, honoured only while idle
//   dbg_addr/dbg_data     combinational register readback
//   alu_op/alu_a/alu_b    ALU opcode (4'hF when parked) and operands
//   alu_out/alu_flag      ALU result and flags (carry/negative/zero)
//   done                  one-cycle pulse in the write-back cycle
//   result/flags          last completed result and flags
//   busy                  high whenever not idle
//   err                   illegal-opcode pulse (only with trap enabled)
// Build option
//   ALU_SEQ_ILLEGAL_TRAP_EN  when defined, opcodes 7..15 pulse err with done;
//                            otherwise err is tied low and they are silent NOPs.
// ----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        instr,
    input  logic                  wr_en,
    input  logic [1:0]            wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [1:0]            dbg_addr,
    output logic [7:0]            dbg_data,
    output logic [3:0]            alu_op,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    input  logic [7:0]            alu_out,
    input  logic [3:0]            alu_flag,
    output logic                  done,
    output logic [7:0]            result,
    output logic [3:0]            flags,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, WB} state_e;

    localparam logic [3:0] OP_PARK   = 4'hF;
    localparam logic [3:0] OP_MAXLEG = 4'd6;
    localparam logic [3:0] CNT_LAST  = 4'(WAIT_CYCLES - 1);

    state_e     state_q,  state_d;
    logic [3:0] op_q,     op_d;
    logic [1:0] rd_q,     rd_d;
    logic [3:0] cnt_q,    cnt_d;
    logic [7:0] regs_q [4];
    logic [7:0] regs_d [4];
    logic [3:0] alu_op_q, alu_op_d;
    logic [7:0] alu_a_q,  alu_a_d;
    logic [7:0] alu_b_q,  alu_b_d;
    logic       done_q,   done_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q,  flags_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic       err_q,    err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        regs_d   = regs_q;
        alu_op_d = OP_PARK;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        err_d    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (wr_en) begin
                    regs_d[wr_addr] = wr_data;
                end
                if (instr.instr_valid) begin
                    state_d = SETUP;
                    op_d    = instr.instr_data[9:6];
                    rd_d    = instr.instr_data[5:4];
                    // Operands come from regs_d so a preload in the accepting
                    // cycle is already visible to this instruction.
                    alu_a_d = regs_d[instr.instr_data[3:2]];
                    alu_b_d = regs_d[instr.instr_data[1:0]];
                end
            end
            SETUP: begin
                cnt_d = 4'd0;
                if (op_q <= OP_MAXLEG) begin
                    state_d  = EXEC;
                    alu_op_d = op_q;
                end else begin
                    // Illegal opcodes never reach the ALU.
                    state_d = WB;
                    done_d  = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    err_d   = 1'b1;
`endif
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d        = WB;
                    cnt_d          = 4'd0;
                    done_d         = 1'b1;
                    result_d       = alu_out;
                    regs_d[rd_q]   = alu_out;
                    // Add/sub keep the ALU's flags; logic ops report zero only.
                    if (op_q <= 4'd1) begin
                        flags_d = alu_flag;
                    end else begin
                        flags_d = (alu_out == 8'h00) ? 4'b0010 : 4'b0000;
                    end
                end else begin
                    cnt_d    = cnt_q + 4'd1;
                    alu_op_d = op_q;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the register file is reset along with the control state because
    // it must read back as zero after reset, including mid-instruction aborts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 4'd0;
            rd_q     <= 2'd0;
            cnt_q    <= 4'd0;
            regs_q   <= '{default: 8'h00};
            alu_op_q <= OP_PARK;
            alu_a_q  <= 8'h00;
            alu_b_q  <= 8'h00;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            flags_q  <= 4'h0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            err_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // same pre-edge values, independent of statement order.
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            regs_q   <= regs_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            err_q    <= err_d;
`endif
        end
    end

    assign instr.instr_ready = (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign dbg_data          = regs_q[dbg_addr];
    assign alu_op            = alu_op_q;
    assign alu_a             = alu_a_q;
    assign alu_b             = alu_b_q;
    assign done              = done_q;
    assign result            = result_q;
    assign flags             = flags_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign err               = err_q;
`else
    assign err               = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer.  A behavioural ALU answers the DUT, a
// cycle-timeline model predicts every output, and a negedge process compares
// them each cycle.  Literal expectations pin the key scenarios.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int W = 1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_flag;
    logic       done, busy, err;
    logic [7:0] result;
    logic [3:0] flags;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer #(.WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (bus),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_flag (alu_flag),
        .done     (done),
        .result   (result),
        .flags    (flags),
        .busy     (busy),
        .err      (err)
    );

    // Behavioural ALU: {flag, out}. Logic ops return a bogus flag so the
    // sequencer must derive its own; parked/illegal opcodes return junk.
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] o;
        logic [3:0] f;
        w = 9'd0;
        o = 8'hEE;
        f = 4'b0101;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; o = w[7:0]; f = {w[8], o[7], o == 8'h00, 1'b0}; end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; o = w[7:0]; f = {w[8], o[7], o == 8'h00, 1'b0}; end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: o = a ^ b;
            4'd5: o = {a[6:0], 1'b0};
            4'd6: o = ~a;
            default: begin o = 8'hEE; f = 4'hF; end
        endcase
        return {f, o};
    endfunction

    always_comb {alu_flag, alu_out} = alu_fn(alu_op, alu_a, alu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model: phase = cycles since the accepting cycle --------
    // -1 idle, 1 setup, 2..W+1 exec, W+2 write-back (illegal skips exec).
    int         phase = -1;
    bit         chk_en = 1'b0;
    logic [3:0] m_op;
    logic [1:0] m_rd;
    logic [7:0] m_a, m_b, m_res;
    logic [3:0] m_flags;
    logic [7:0] m_regs [4];

    always @(posedge clk) begin
        if (!rst_n) begin
            phase   = -1;
            m_regs  = '{default: 8'h00};
            m_a     = 8'h00;
            m_b     = 8'h00;
            m_res   = 8'h00;
            m_flags = 4'h0;
        end else if (phase < 0) begin
            if (wr_en) m_regs[wr_addr] = wr_data;
            if (bus.instr_valid) begin
                m_op  = bus.instr_data[9:6];
                m_rd  = bus.instr_data[5:4];
                m_a   = m_regs[bus.instr_data[3:2]];
                m_b   = m_regs[bus.instr_data[1:0]];
                phase = 1;
            end
        end else if (phase == 1) begin
            phase = (m_op <= 4'd6) ? 2 : W + 2;
        end else if (phase <= W + 1) begin
            if (phase == W + 1) begin
                logic [11:0] r;
                r       = alu_fn(m_op, m_a, m_b);
                m_res   = r[7:0];
                m_flags = (m_op <= 4'd1) ? r[11:8] : ((r[7:0] == 8'h00) ? 4'b0010 : 4'b0000);
                m_regs[m_rd] = r[7:0];
            end
            phase = phase + 1;
        end else begin
            phase = -1;
        end
    end

    // ---------------- per-cycle compare + alu_op trace -----------------------
    bit         rec = 1'b0;
    logic [3:0] op_trace [$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  bus.instr_ready, phase < 0);
            check("busy",   busy,   phase >= 1);
            check("done",   done,   phase == W + 2);
            check("err",    err,    (phase == W + 2 && m_op > 4'd6) ? TRAP : 1'b0);
            check("alu_op", alu_op, (phase >= 2 && phase <= W + 1) ? m_op : 4'hF);
            check("alu_a",  alu_a,  m_a);
            check("alu_b",  alu_b,  m_b);
            check("result", result, m_res);
            check("flags",  flags,  m_flags);
            check("dbg",    dbg_data, m_regs[dbg_addr]);
        end
        if (rec && (op_trace.size() == 0 || op_trace[$] != alu_op)) op_trace.push_back(alu_op);
    end

    // ---------------- driver -------------------------------------------------
    logic last_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.instr_ready && n < 20) begin tick(); n++; end
        if (!bus.instr_ready) check("idle_timeout", bus.instr_ready, 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input bit pre_en, input logic [1:0] pre_a,
                         input logic [7:0] pre_d, input bit poke, input int exp_lat);
        int n;
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr_data  = {op, rd, rs1, rs2};
        wr_en = pre_en; wr_addr = pre_a; wr_data = pre_d;
        tick();
        bus.instr_valid = 1'b0;
        wr_en = 1'b0;
        if (poke) begin wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hAA; end
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        check("latency", n, exp_lat);
        last_err = err;
        wr_en = 1'b0;
        tick();
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
        dbg_addr = 2'd0;
    endtask

    logic [3:0] exp_tr [5] = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF};
    logic [7:0] exp_logic [5] = '{8'h05, 8'hAF, 8'hAA, 8'h4A, 8'h5A};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'h00; dbg_addr = 2'd0;
        bus.instr_valid = 1'b0; bus.instr_data = 10'd0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_result", result, 8'h00);
        check("rst_flags",  flags,  4'h0);
        check("rst_alu_op", alu_op, 4'hF);
        check("rst_done",   done,   1'b0);
        check("rst_ready",  bus.instr_ready, 1'b1);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);
        rst_n = 1'b1;
        tick();

        // ADD r1+r2 -> r0
        preload(2'd1, 8'hF0);
        preload(2'd2, 8'h20);
        issue(4'd0, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("add_result", result, 8'h10);
        check("add_flags",  flags,  4'b1000);
        check_reg("add_r0", 2'd0, 8'h10);

        // rd == rs1 reads old, writes new
        issue(4'd0, 2'd1, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check_reg("alias_r1", 2'd1, 8'h10);

        // preload in the accepting cycle is visible: r1(10) + r3(05)
        issue(4'd0, 2'd2, 2'd1, 2'd3, 1, 2'd3, 8'h05, 0, 3);
        check_reg("bypass_r2", 2'd2, 8'h15);

        // SUB to zero, then AND
        preload(2'd1, 8'h33);
        preload(2'd2, 8'h33);
        issue(4'd1, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("sub_result", result, 8'h00);
        check("sub_flags",  flags,  4'b0010);
        issue(4'd2, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("and_result", result, 8'h33);
        check("and_flags",  flags,  4'b0000);

        // logic ops 2..6 on A5 / 0F
        preload(2'd1, 8'hA5);
        preload(2'd2, 8'h0F);
        for (int op = 2; op <= 6; op++) begin
            issue(4'(op), 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
            check("logic_result", result, exp_logic[op - 2]);
        end
        // zero from a logic op: A5 & 5A
        preload(2'd2, 8'h5A);
        issue(4'd2, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("and0_flags", flags, 4'b0010);

        // back-to-back ADDs
        preload(2'd1, 8'hF0);
        preload(2'd2, 8'h20);
        op_trace.delete();
        rec = 1'b1;
        issue(4'd0, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("b2b_result0", result, 8'h10);
        issue(4'd0, 2'd3, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("b2b_result1", result, 8'h10);
        rec = 1'b0;
        check("trace_len", op_trace.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < op_trace.size()) check("trace_op", op_trace[i], exp_tr[i]);

        // illegal opcode 9
        issue(4'd9, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00, 0, 2);
        check("ill_err",    last_err, TRAP);
        check("ill_result", result, 8'h10);
        check("ill_flags",  flags,  4'b1000);
        check_reg("ill_r0", 2'd0, 8'h33);

        // wr_en while busy is ignored; r0 only takes the write-back result
        issue(4'd0, 2'd0, 2'd1, 2'd2, 0, 2'd0, 8'h00, 1, 3);
        check_reg("poke_r0", 2'd0, 8'h10);

        // reset during EXEC aborts the instruction
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr_data  = {4'd0, 2'd0, 2'd1, 2'd2};
        tick();
        bus.instr_valid = 1'b0;
        tick();
        check("pre_rst_exec_op", alu_op, 4'h0);
        rst_n = 1'b0;
        tick();
        check("abort_done",   done,   1'b0);
        check("abort_busy",   busy,   1'b0);
        check("abort_alu_op", alu_op, 4'hF);
        check("abort_alu_a",  alu_a,  8'h00);
        check("abort_result", result, 8'h00);
        check_reg("abort_r0", 2'd0, 8'h00);
        rst_n = 1'b1;
        tick();

        // normal operation after reset: 0 + 0
        issue(4'd0, 2'd1, 2'd0, 2'd2, 0, 2'd0, 8'h00, 0, 3);
        check("post_rst_flags", flags, 4'b0010);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
